// File: rtl/proc_pkg.sv
// proc_pkg: constants and types shared by the fetch stage and the processor core.
//   INST_W/ADDR_W  instruction word and PC widths
//   MAX_PC         program length in words; fetch stops once PC reaches it
//   FIFO_DEPTH     prefetch buffer entries (power of two, >=2)
//   fetch_state_t  fetch FSM encoding
//   OP_*           primary opcode field values decoded by the core
package proc_pkg;

    localparam int INST_W     = 32;
    localparam int ADDR_W     = 3;
    localparam int MAX_PC     = 7;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic [5:0] opcode(input logic [INST_W-1:0] inst);
        return inst[INST_W-1 -: 6];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch buffer between instruction memory and the core.
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        drop all entries (wins over push/pop)
//   push, wdata  write an entry at the tail
//   pop          retire the head entry
//   rdata        head entry, zero when empty
//   count        number of valid entries
module fetch_fifo
    import proc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]             mem [DEPTH];
    logic [$clog2(DEPTH)-1:0] wp, rp;

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wp] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clear) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = (count != '0) ? mem[rp] : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: walks the PC over instruction memory and feeds the core through a prefetch FIFO.
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin fetching from PC 0 (IDLE or DONE only)
//   flush, flush_pc       redirect: drop buffered/in-flight words, continue at flush_pc
//   imem_rd_en/addr       registered read request to the synchronous instruction memory
//   imem_rdata            read data, valid the cycle after imem_rd_en
//   inst_valid/data/pc    FIFO head presented to the core
//   inst_ready            core accepts the head this cycle
//   done                  whole program fetched and consumed
module fetch_unit
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              done
);

    localparam int              CW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] PC_END = (ADDR_W+1)'(MAX_PC);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, cur_pc, rsp_pc;
    logic              rsp, fl, go, pop, issue;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;

    assign fl     = flush && state != IDLE;
    assign go     = start && !fl && (state == IDLE || state == DONE);
    assign cur_pc = go ? '0 : pc;
    assign pop    = inst_valid && inst_ready;

    // Inflight reads are the one on the memory port (imem_rd_en) and the one
    // returning data this cycle (rsp); both already own a FIFO slot.
    assign occ   = (CW+1)'(count) + (CW+1)'(imem_rd_en) + (CW+1)'(rsp) - (CW+1)'(pop);
    assign issue = (state == RUN || go) && !fl && {1'b0, cur_pc} < PC_END
                   && occ < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        if (fl) begin
            pc_n    = flush_pc;
            state_n = ({1'b0, flush_pc} >= PC_END) ? DRAIN : RUN;
        end else begin
            if (go) begin
                state_n = RUN;
                pc_n    = '0;
            end
            if (issue) begin
                pc_n = cur_pc + 1'b1;
                if ({1'b0, cur_pc} == PC_END - 1'b1)
                    state_n = DRAIN;
            end
            if (state == DRAIN && !imem_rd_en && !rsp && count == '0)
                state_n = DONE;
        end
    end

    // Clearing rsp on flush discards the word already requested from memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= '0;
            imem_rd_en <= 1'b0;
            imem_addr  <= '0;
            rsp        <= 1'b0;
            rsp_pc     <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            imem_rd_en <= issue;
            if (issue)
                imem_addr <= cur_pc;
            rsp        <= imem_rd_en && !fl;
            rsp_pc     <= imem_addr;
            done       <= state_n == DONE;
        end
    end

    fetch_fifo #(.W(INST_W + ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (fl),
        .push  (rsp),
        .pop   (pop),
        .wdata ({imem_rdata, rsp_pc}),
        .rdata ({inst_data, inst_pc}),
        .count (count)
    );

    assign inst_valid = count != '0;

endmodule
